// File: rtl/layer_seq_pkg.sv
// rtl/layer_seq_pkg.sv - shared types and constants for the layer sequencer
// Contents: layer type, sequencer state and error code enums; timeout width.
package layer_seq_pkg;

  typedef enum logic [1:0] {
    LT_VECTOR   = 2'b00,
    LT_WINOGRAD = 2'b01,
    LT_SE       = 2'b10,
    LT_RSVD     = 2'b11
  } layer_type_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } seq_state_e;

  typedef enum logic [1:0] {
    EC_NONE      = 2'b00,
    EC_TIMEOUT   = 2'b01,
    EC_BAD_TYPE  = 2'b10,
    EC_BAD_COUNT = 2'b11
  } err_code_e;

  // Default watchdog is 2**TIMEOUT_W cycles.
  localparam int TIMEOUT_W = 12;

endpackage

// File: rtl/layer_desc_table.sv
// rtl/layer_desc_table.sv - layer descriptor register file, 1 sync write, 1 async read
// Ports: clk; we/waddr/wdata write port; raddr/rdata combinational read port.
// Contents are not reset: they are undefined until written by the host.
module layer_desc_table #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [1:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [1:0]    rdata
);

  logic [1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - walks the descriptor table and drives Main_Controller layer by layer
// Ports: clk, rst_n (async, active low); cfg_we/cfg_addr/cfg_type table write;
//        cfg_num_layers, run, abort sequence control; mc_start/mc_layer_type/mc_done
//        Main_Controller handshake; busy, cur_layer, seq_done, err, err_code status.
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int   MAX_LAYERS     = 16,
  parameter int   TIMEOUT_CYCLES = 1 << TIMEOUT_W,
  localparam int  IDX_W          = $clog2(MAX_LAYERS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [1:0]       cfg_type,
  input  logic [IDX_W:0]   cfg_num_layers,
  input  logic             run,
  input  logic             abort,
  output logic             mc_start,
  output logic [1:0]       mc_layer_type,
  input  logic             mc_done,
  output logic             busy,
  output logic [IDX_W-1:0] cur_layer,
  output logic             seq_done,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  seq_state_e       state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W:0]   num_q;
  logic [CNT_W-1:0] tmo_cnt;
  layer_type_e      type_q;
  logic             err_q;
  err_code_e        err_code_q;

  logic [IDX_W-1:0] rd_addr;
  logic [1:0]       rd_type;
  logic             last_layer;

  assign busy = (state == ST_ISSUE) || (state == ST_WAIT);

  // The type is captured on the edge that enters ISSUE, so the table is read
  // at the index the sequencer is about to move to, not the current one.
  assign rd_addr    = (state == ST_IDLE) ? '0 : idx + 1'b1;
  assign last_layer = ({1'b0, idx} == num_q - 1'b1);

  layer_desc_table #(
    .DEPTH (MAX_LAYERS),
    .AW    (IDX_W)
  ) u_table (
    .clk   (clk),
    .we    (cfg_we && !busy),
    .waddr (cfg_addr),
    .wdata (cfg_type),
    .raddr (rd_addr),
    .rdata (rd_type)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      num_q      <= '0;
      tmo_cnt    <= '0;
      type_q     <= LT_VECTOR;
      err_q      <= 1'b0;
      err_code_q <= EC_NONE;
    end else if (abort) begin
      // Abort overrides mc_done, timeout and run in every state.
      state      <= ST_IDLE;
      err_q      <= 1'b0;
      err_code_q <= EC_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run) begin
            err_q      <= 1'b0;
            err_code_q <= EC_NONE;
            num_q      <= cfg_num_layers;
            if (cfg_num_layers == '0) begin
              state <= ST_DONE;
            end else if (cfg_num_layers > (IDX_W+1)'(MAX_LAYERS)) begin
              state      <= ST_ERR;
              err_q      <= 1'b1;
              err_code_q <= EC_BAD_COUNT;
            end else begin
              state  <= ST_ISSUE;
              idx    <= '0;
              type_q <= layer_type_e'(rd_type);
            end
          end
        end
        ST_ISSUE: begin
          if (type_q == LT_RSVD) begin
            state      <= ST_ERR;
            err_q      <= 1'b1;
            err_code_q <= EC_BAD_TYPE;
          end else begin
            state   <= ST_WAIT;
            tmo_cnt <= '0;
          end
        end
        ST_WAIT: begin
          // mc_done takes priority over a timeout in the same cycle.
          if (mc_done) begin
            if (last_layer) begin
              state <= ST_DONE;
            end else begin
              state  <= ST_ISSUE;
              idx    <= idx + 1'b1;
              type_q <= layer_type_e'(rd_type);
            end
          end else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state      <= ST_ERR;
            err_q      <= 1'b1;
            err_code_q <= EC_TIMEOUT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mc_start      = (state == ST_ISSUE) && (type_q != LT_RSVD);
  assign mc_layer_type = type_q;
  assign cur_layer     = idx;
  assign seq_done      = (state == ST_DONE);
  assign err           = err_q;
  assign err_code      = err_code_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - self-checking bench for layer_sequencer
module tb_layer_sequencer;

  localparam int MAXL = 16;
  localparam int TMO  = 4096;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [1:0] cfg_type = '0;
  logic [4:0] cfg_num_layers = '0;
  logic       run = 1'b0;
  logic       abort = 1'b0;
  logic       mc_done = 1'b0;
  logic       mc_start;
  logic [1:0] mc_layer_type;
  logic       busy;
  logic [3:0] cur_layer;
  logic       seq_done;
  logic       err;
  logic [1:0] err_code;

  layer_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_type       (cfg_type),
    .cfg_num_layers (cfg_num_layers),
    .run            (run),
    .abort          (abort),
    .mc_start       (mc_start),
    .mc_layer_type  (mc_layer_type),
    .mc_done        (mc_done),
    .busy           (busy),
    .cur_layer      (cur_layer),
    .seq_done       (seq_done),
    .err            (err),
    .err_code       (err_code)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: phase of the sequence, layer being worked on,
  // cycles spent waiting for the current layer, and a shadow descriptor table.
  localparam int P_IDLE = 0, P_ISSUE = 1, P_WAIT = 2, P_DONE = 3, P_ERR = 4;
  int         m_ph;
  int         m_idx;
  int         m_num;
  int         m_waited;
  logic [1:0] m_tab [MAXL];
  logic       m_err;
  int         m_code;

  wire m_busy = (m_ph == P_ISSUE) || (m_ph == P_WAIT);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= P_IDLE; m_idx <= 0; m_num <= 0; m_waited <= 0; m_err <= 1'b0; m_code <= 0;
    end else begin
      if (cfg_we && !m_busy) m_tab[cfg_addr] <= cfg_type;
      if (abort) begin
        m_ph <= P_IDLE; m_err <= 1'b0; m_code <= 0;
      end else begin
        case (m_ph)
          P_IDLE: if (run) begin
            m_err <= 1'b0; m_code <= 0; m_num <= int'(cfg_num_layers);
            if (cfg_num_layers == 0) m_ph <= P_DONE;
            else if (int'(cfg_num_layers) > MAXL) begin m_ph <= P_ERR; m_err <= 1'b1; m_code <= 3; end
            else begin m_ph <= P_ISSUE; m_idx <= 0; end
          end
          P_ISSUE: if (m_tab[m_idx] == 2'b11) begin m_ph <= P_ERR; m_err <= 1'b1; m_code <= 2; end
                   else begin m_ph <= P_WAIT; m_waited <= 0; end
          P_WAIT: begin
            if (mc_done) begin
              if (m_idx == m_num - 1) m_ph <= P_DONE;
              else begin m_idx <= m_idx + 1; m_ph <= P_ISSUE; end
            end else if (m_waited + 1 == TMO) begin
              m_ph <= P_ERR; m_err <= 1'b1; m_code <= 1;
            end else m_waited <= m_waited + 1;
          end
          default: m_ph <= P_IDLE;
        endcase
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("busy", busy, m_busy);
    chk("mc_start", mc_start, (m_ph == P_ISSUE) && (m_tab[m_idx] != 2'b11));
    chk("seq_done", seq_done, m_ph == P_DONE);
    chk("err", err, m_err);
    chk("err_code", err_code, m_code);
    chk("cur_layer", cur_layer, m_idx);
    if (m_busy) chk("mc_layer_type", mc_layer_type, m_tab[m_idx]);
  end

  // Event log for the literal expectations.
  logic [1:0] start_q[$];
  int seq_cnt = 0;
  int seq_cyc = -1;
  always @(negedge clk) begin
    if (mc_start) start_q.push_back(mc_layer_type);
    if (seq_done) begin seq_cnt++; seq_cyc = cyc; end
  end

  // Main_Controller stand-in: mc_done resp_delay cycles after each mc_start,
  // optionally with a simultaneous abort on one chosen layer.
  bit resp_en = 1'b0;
  int resp_delay = 4;
  int abort_layer = -1;
  initial begin
    forever begin
      @(negedge clk);
      if (resp_en && mc_start) begin
        automatic int lyr = int'(cur_layer);
        repeat (resp_delay) @(posedge clk);
        #1;
        mc_done = 1'b1;
        if (lyr == abort_layer) abort = 1'b1;
        @(posedge clk);
        #1;
        mc_done = 1'b0;
        abort = 1'b0;
      end
    end
  end

  int run_cyc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_desc(input int a, input int t);
    cfg_we = 1'b1; cfg_addr = 4'(a); cfg_type = 2'(t);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_run(input int n);
    cfg_num_layers = 5'(n); run = 1'b1;
    tick();
    run = 1'b0;
    run_cyc = cyc;
  endtask

  task automatic wait_end(input int limit);
    int n = 0;
    while (busy && n < limit) begin tick(); n++; end
    chk("wait_end_bound", busy, 0);
  endtask

  task automatic clear_log();
    start_q.delete(); seq_cnt = 0; seq_cyc = -1;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_mc_start", mc_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_seq_done", seq_done, 0);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_cur_layer", cur_layer, 0);
    chk("rst_type", mc_layer_type, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // 3 layers, done 4 cycles after each start
    resp_en = 1'b1; resp_delay = 4;
    write_desc(0, 0); write_desc(1, 1); write_desc(2, 2);
    clear_log();
    pulse_run(3);
    wait_end(200);
    repeat (3) tick();
    chk("s1_starts", start_q.size(), 3);
    if (start_q.size() == 3) begin
      chk("s1_type0", start_q[0], 0);
      chk("s1_type1", start_q[1], 1);
      chk("s1_type2", start_q[2], 2);
    end
    chk("s1_seq_cnt", seq_cnt, 1);
    chk("s1_seq_cyc", seq_cyc, run_cyc + 15);

    // num = 0
    clear_log();
    pulse_run(0);
    repeat (3) tick();
    chk("s2_starts", start_q.size(), 0);
    chk("s2_seq_cnt", seq_cnt, 1);
    chk("s2_seq_cyc", seq_cyc, run_cyc);

    // Timeout after layer 0
    resp_en = 1'b0;
    write_desc(0, 0); write_desc(1, 1);
    clear_log();
    pulse_run(2);
    wait_end(TMO + 100);
    chk("s3_err_cyc", cyc, run_cyc + 1 + TMO);
    chk("s3_err", err, 1);
    chk("s3_code", err_code, 1);
    repeat (3) tick();
    chk("s3_err_held", err, 1);
    chk("s3_starts", start_q.size(), 1);
    chk("s3_seq_cnt", seq_cnt, 0);

    // Reserved type on layer 1
    resp_en = 1'b1;
    write_desc(0, 0); write_desc(1, 3);
    clear_log();
    pulse_run(2);
    wait_end(200);
    chk("s4_err", err, 1);
    chk("s4_code", err_code, 2);
    chk("s4_cur_layer", cur_layer, 1);
    repeat (3) tick();
    chk("s4_starts", start_q.size(), 1);
    if (start_q.size() == 1) chk("s4_type0", start_q[0], 0);
    chk("s4_seq_cnt", seq_cnt, 0);

    // Abort together with mc_done on layer 2 of 4
    abort_layer = 2;
    write_desc(0, 0); write_desc(1, 1); write_desc(2, 2); write_desc(3, 1);
    clear_log();
    pulse_run(4);
    wait_end(200);
    chk("s5_abort_cyc", cyc, run_cyc + 15);
    chk("s5_busy", busy, 0);
    chk("s5_err", err, 0);
    repeat (6) tick();
    chk("s5_starts", start_q.size(), 3);
    chk("s5_seq_cnt", seq_cnt, 0);
    abort_layer = -1;

    // Write and run while busy are dropped; bad count
    write_desc(0, 1); write_desc(1, 1); write_desc(2, 1);
    clear_log();
    pulse_run(3);
    write_desc(2, 2);
    cfg_num_layers = 5'd1; run = 1'b1; tick(); run = 1'b0;
    wait_end(200);
    repeat (3) tick();
    chk("s6_starts", start_q.size(), 3);
    if (start_q.size() == 3) chk("s6_type2", start_q[2], 1);
    chk("s6_seq_cnt", seq_cnt, 1);
    pulse_run(17);
    chk("s6_bad_err", err, 1);
    chk("s6_bad_code", err_code, 3);
    chk("s6_bad_busy", busy, 0);
    repeat (3) tick();
    chk("s6_bad_starts", start_q.size(), 3);

    // Async reset mid-sequence
    pulse_run(3);
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_mc_start", mc_start, 0);
    chk("ar_cur_layer", cur_layer, 0);
    chk("ar_type", mc_layer_type, 0);
    chk("ar_err", err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    resp_en = 1'b0;
    repeat (10) tick();
    chk("ar_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
